reorder_buffer: RTL and testbench
=================================

Name: reorder_buffer

Overview:
- Circular in-order commit buffer downstream of the reservation station and load/store buffer.
- Allocates a rob id for each decoded instruction, captures results broadcast by the RS (ALU) and LSB, and answers operand queries from the decoder.
- Retires at most one instruction per cycle to the register file or LSB, and raises a flush on branch mispredict.

Parameters:
ROB_SIZE_BIT, 4, log2 of entry count (16 entries); equals `robsize width of rob ids

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low = freeze all state
issue_valid  in  1  decoder issues an instruction this cycle
issue_type  in  2  `rob_reg=0, `rob_store=1, `rob_branch=2, `rob_exit=3
issue_rd  in  5  destination register (reg type)
issue_pred_taken  in  1  predicted direction (branch)
issue_alt_pc  in  32  pc to redirect to on mispredict
issue_done  in  1  result already known at issue (lui/auipc/jal)
issue_value  in  32  result when issue_done
rob_full  out  1  no free entry (combinational from count)
rob_tail  out  ROB_SIZE_BIT  id given to next issued instruction
rs_ready  in  1  ALU result broadcast valid
rs_rob_id  in  ROB_SIZE_BIT  broadcast tag
rs_value  in  32  result; for branch, bit0 = actual taken
lsb_ready  in  1  LSB broadcast valid (load data / store address ready)
lsb_rob_id  in  ROB_SIZE_BIT  broadcast tag
lsb_value  in  32  load data
query_id1, query_id2  in  ROB_SIZE_BIT  decoder operand tags
query_ready1, query_ready2  out  1  tagged value available
query_value1, query_value2  out  32  tagged value
commit_valid  out  1  one-cycle register write pulse
commit_rd  out  5  destination
commit_value  out  32  value
commit_rob_id  out  ROB_SIZE_BIT  retiring id (regfile clears dep on match)
store_commit  out  1  pulse: LSB may perform the store
store_commit_rob_id  out  ROB_SIZE_BIT  store id
flush  out  1  mispredict pulse; all stages squash
flush_pc  out  32  redirect target
halt  out  1  sticky after exit retires

Behaviour:
- Reset: head=tail=count=0, all busy/done=0. All outputs 0, except rob_tail=0.
- rdy=0: no state or output register changes. Consumers are also frozen, so held pulses are not double-counted.
- rob_full = (count == 2^ROB_SIZE_BIT).
- Issue is accepted when issue_valid && !rob_full && !flush_pending. It writes entry[tail] with busy=1, done=issue_done, and the issue fields. tail increments mod size.
- Writeback on rs_ready or lsb_ready:
  - Entry[id] is written only if busy: value<=bus, done<=1.
  - Stores take only done from LSB.
  - Both buses in the same cycle with different ids: both written. Same id is illegal.
  - Writeback to a non-busy entry is ignored (stale post-flush result).
- Commit: if entry[head] busy && done, retire it on this edge. Outputs are registered, so they are valid in the following cycle.
  - reg: commit_valid=1 with rd, value, id. Committing rd=0 is allowed; the regfile ignores it.
  - store: store_commit=1 with id.
  - branch: if value[0] != pred_taken, flush=1 and flush_pc=alt_pc. Otherwise no pulse.
  - exit: halt<=1 (sticky). No further commits.
  - Retiring clears busy, advances head, and decrements count. Pulse outputs are otherwise 0 on every rdy cycle.
- Simultaneous issue and commit: count unchanged. An issue while full is refused even if a commit occurs that cycle.
- Mispredict commit edge: the same-cycle issue is discarded.
  - Next edge: head=tail=count=0 and all busy=0, driven by the internal flush_pending held during the flush-pulse cycle.
  - Issue is blocked during the flush-pulse cycle.
- Query (combinational), checked in priority order:
  1. entry done → its value.
  2. rs_ready && rs_rob_id==id → rs_value.
  3. lsb_ready && lsb_rob_id==id → lsb_value.
  4. Otherwise ready=0, value=0.
- Width rules: pointers ROB_SIZE_BIT bits with natural wrap. count is ROB_SIZE_BIT+1 bits.

Decomposition:
- const.v gains `rob_type_size (2), the four rob type codes, and `rob_size_bit tying to `robsize.
- Single module. No sub-module; the query mux is a function or generate block.

Test Plan:
- Reset, issue reg rd=5 with issue_done=1, value=0x11 → next cycle rob_tail=1. Following cycle commit_valid=1, rd=5, value=0x11, id=0.
- Issue id0 (not done) and id1 (done, 0x22); rs broadcast id0=0x33 → commits in order: 0x33, then 0x22 one cycle later. No commit before the broadcast.
- Issue 16 entries with none done → rob_full=1 and the 17th issue is ignored. Broadcast id0 → head commits and rob_full drops. Tail wraps from 15 to 0 on the next issue.
- Branch issued with pred_taken=0 and alt_pc=0x100; rs broadcast value=1 → flush=1, flush_pc=0x100. Next cycle count=0 and rob_tail=0. A stale rs broadcast to an old id is ignored.
- Store issued; lsb_ready for its id → store_commit=1 with that id. No commit_valid.
- query_id1=3 while rs broadcasts id3=0xAB in the same cycle → query_ready1=1, query_value1=0xAB. Exit committed → halt stays 1 until rst.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry kinds and default sizing.
// ROB_SIZE_BIT_DEF matches the width of the rob ids used elsewhere.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_BIT_DEF = 4;
  localparam int ROB_TYPE_SIZE    = 2;

  typedef enum logic [ROB_TYPE_SIZE-1:0] {
    ROB_REG    = 2'd0,
    ROB_STORE  = 2'd1,
    ROB_BRANCH = 2'd2,
    ROB_EXIT   = 2'd3
  } rob_type_e;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order commit buffer: allocates rob ids, captures RS/LSB
// results, answers operand queries and retires one entry per cycle.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE_BIT = ROB_SIZE_BIT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    issue_valid,
  input  logic [1:0]              issue_type,
  input  logic [4:0]              issue_rd,
  input  logic                    issue_pred_taken,
  input  logic [31:0]             issue_alt_pc,
  input  logic                    issue_done,
  input  logic [31:0]             issue_value,
  output logic                    rob_full,
  output logic [ROB_SIZE_BIT-1:0] rob_tail,
  input  logic                    rs_ready,
  input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
  input  logic [31:0]             rs_value,
  input  logic                    lsb_ready,
  input  logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
  input  logic [31:0]             lsb_value,
  input  logic [ROB_SIZE_BIT-1:0] query_id1,
  input  logic [ROB_SIZE_BIT-1:0] query_id2,
  output logic                    query_ready1,
  output logic                    query_ready2,
  output logic [31:0]             query_value1,
  output logic [31:0]             query_value2,
  output logic                    commit_valid,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_value,
  output logic [ROB_SIZE_BIT-1:0] commit_rob_id,
  output logic                    store_commit,
  output logic [ROB_SIZE_BIT-1:0] store_commit_rob_id,
  output logic                    flush,
  output logic [31:0]             flush_pc,
  output logic                    halt
);

  localparam int DEPTH = 2 ** ROB_SIZE_BIT;
  localparam logic [ROB_SIZE_BIT:0] LP_FULL =
    {1'b1, {ROB_SIZE_BIT{1'b0}}};

  logic [DEPTH-1:0]        r_busy;
  logic [DEPTH-1:0]        r_done;
  logic [DEPTH-1:0]        r_pred;
  rob_type_e               r_type   [DEPTH];
  logic [4:0]              r_rd     [DEPTH];
  logic [31:0]             r_alt_pc [DEPTH];
  logic [31:0]             r_value  [DEPTH];
  logic [ROB_SIZE_BIT-1:0] r_head;
  logic [ROB_SIZE_BIT-1:0] r_tail;
  logic [ROB_SIZE_BIT:0]   r_count;
  logic                    r_flush_pending;

  logic                    w_commit;
  logic                    w_mispredict;
  logic                    w_issue;
  rob_type_e               w_head_type;
  logic [31:0]             w_head_value;

  assign rob_full     = (r_count == LP_FULL);
  assign rob_tail     = r_tail;
  assign w_head_type  = r_type[r_head];
  assign w_head_value = r_value[r_head];

  // Nothing past a taken flush or a retired exit may retire.
  assign w_commit = r_busy[r_head] && r_done[r_head] &&
                    !r_flush_pending && !halt;
  assign w_mispredict = w_commit && (w_head_type == ROB_BRANCH) &&
                        (w_head_value[0] != r_pred[r_head]);
  assign w_issue = issue_valid && !rob_full &&
                   !r_flush_pending && !w_mispredict;

  function automatic logic [32:0] f_query(
    input logic [ROB_SIZE_BIT-1:0] id
  );
    if (r_done[id])
      return {1'b1, r_value[id]};
    if (rs_ready && (rs_rob_id == id))
      return {1'b1, rs_value};
    if (lsb_ready && (lsb_rob_id == id))
      return {1'b1, lsb_value};
    return 33'd0;
  endfunction

  always_comb begin
    {query_ready1, query_value1} = f_query(query_id1);
    {query_ready2, query_value2} = f_query(query_id2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy              <= '0;
      r_done              <= '0;
      r_head              <= '0;
      r_tail              <= '0;
      r_count             <= '0;
      r_flush_pending     <= 1'b0;
      commit_valid        <= 1'b0;
      commit_rd           <= '0;
      commit_value        <= '0;
      commit_rob_id       <= '0;
      store_commit        <= 1'b0;
      store_commit_rob_id <= '0;
      flush               <= 1'b0;
      flush_pc            <= '0;
      halt                <= 1'b0;
    end else if (rdy) begin
      commit_valid <= 1'b0;
      store_commit <= 1'b0;
      flush        <= 1'b0;
      if (r_flush_pending) begin
        r_busy          <= '0;
        r_done          <= '0;
        r_head          <= '0;
        r_tail          <= '0;
        r_count         <= '0;
        r_flush_pending <= 1'b0;
      end else begin
        if (rs_ready && r_busy[rs_rob_id]) begin
          r_done[rs_rob_id] <= 1'b1;
          if (r_type[rs_rob_id] != ROB_STORE)
            r_value[rs_rob_id] <= rs_value;
        end
        if (lsb_ready && r_busy[lsb_rob_id]) begin
          r_done[lsb_rob_id] <= 1'b1;
          if (r_type[lsb_rob_id] != ROB_STORE)
            r_value[lsb_rob_id] <= lsb_value;
        end
        if (w_issue) begin
          r_busy[r_tail]   <= 1'b1;
          r_done[r_tail]   <= issue_done;
          r_type[r_tail]   <= rob_type_e'(issue_type);
          r_rd[r_tail]     <= issue_rd;
          r_pred[r_tail]   <= issue_pred_taken;
          r_alt_pc[r_tail] <= issue_alt_pc;
          r_value[r_tail]  <= issue_value;
          r_tail           <= r_tail + 1'b1;
        end
        if (w_commit) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
          unique case (w_head_type)
            ROB_REG: begin
              commit_valid  <= 1'b1;
              commit_rd     <= r_rd[r_head];
              commit_value  <= w_head_value;
              commit_rob_id <= r_head;
            end
            ROB_STORE: begin
              store_commit        <= 1'b1;
              store_commit_rob_id <= r_head;
            end
            ROB_BRANCH: begin
              if (w_mispredict) begin
                flush           <= 1'b1;
                flush_pc        <= r_alt_pc[r_head];
                r_flush_pending <= 1'b1;
              end
            end
            ROB_EXIT: halt <= 1'b1;
          endcase
        end
        r_count <= r_count
                 + (ROB_SIZE_BIT+1)'(w_issue)
                 - (ROB_SIZE_BIT+1)'(w_commit);
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: commit scoreboard, query
// vector table and hand-written full/flush/exit sequences.
module tb_reorder_buffer;

  localparam logic [1:0] T_REG = 2'd0;
  localparam logic [1:0] T_ST  = 2'd1;
  localparam logic [1:0] T_BR  = 2'd2;
  localparam logic [1:0] T_EX  = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        issue_valid = 1'b0;
  logic [1:0]  issue_type = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_pred_taken = 1'b0;
  logic [31:0] issue_alt_pc = '0;
  logic        issue_done = 1'b0;
  logic [31:0] issue_value = '0;
  logic        rob_full;
  logic [3:0]  rob_tail;
  logic        rs_ready = 1'b0;
  logic [3:0]  rs_rob_id = '0;
  logic [31:0] rs_value = '0;
  logic        lsb_ready = 1'b0;
  logic [3:0]  lsb_rob_id = '0;
  logic [31:0] lsb_value = '0;
  logic [3:0]  query_id1 = '0;
  logic [3:0]  query_id2 = '0;
  logic        query_ready1, query_ready2;
  logic [31:0] query_value1, query_value2;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [3:0]  commit_rob_id;
  logic        store_commit;
  logic [3:0]  store_commit_rob_id;
  logic        flush;
  logic [31:0] flush_pc;
  logic        halt;

  reorder_buffer #(.ROB_SIZE_BIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_type(issue_type),
    .issue_rd(issue_rd), .issue_pred_taken(issue_pred_taken),
    .issue_alt_pc(issue_alt_pc), .issue_done(issue_done),
    .issue_value(issue_value),
    .rob_full(rob_full), .rob_tail(rob_tail),
    .rs_ready(rs_ready), .rs_rob_id(rs_rob_id), .rs_value(rs_value),
    .lsb_ready(lsb_ready), .lsb_rob_id(lsb_rob_id),
    .lsb_value(lsb_value),
    .query_id1(query_id1), .query_id2(query_id2),
    .query_ready1(query_ready1), .query_ready2(query_ready2),
    .query_value1(query_value1), .query_value2(query_value2),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_rob_id(commit_rob_id),
    .store_commit(store_commit),
    .store_commit_rob_id(store_commit_rob_id),
    .flush(flush), .flush_pc(flush_pc), .halt(halt)
  );

  always #5 clk = ~clk;

  // expected retirement events: 0 reg, 1 store, 2 flush
  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [3:0]  id;
  } exp_t;

  typedef struct {
    logic        rs_r;
    logic [3:0]  rs_id;
    logic [31:0] rs_v;
    logic        l_r;
    logic [3:0]  l_id;
    logic [31:0] l_v;
    logic [3:0]  q1;
    logic [3:0]  q2;
    logic        e_r1;
    logic [31:0] e_v1;
    logic        e_r2;
    logic [31:0] e_v2;
  } qvec_t;

  exp_t       exp_q[$];
  exp_t       e_mon;
  qvec_t      tbl[7];
  int         total = 0;
  int         bad = 0;
  logic [3:0] m_tail = '0;
  logic       rdy_q = 1'b0;
  logic       ok;

  always @(posedge clk) rdy_q <= rdy;

  always @(negedge clk) begin
    if (rdy_q && !rst && (commit_valid || store_commit || flush)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_retire: cv=%0b sc=%0b fl=%0b want none",
                 commit_valid, store_commit, flush);
      end else begin
        e_mon = exp_q.pop_front();
        case (e_mon.kind)
          2'd0: ok = {commit_valid, store_commit, flush} == 3'b100 &&
                     commit_rd == e_mon.rd &&
                     commit_value == e_mon.val &&
                     commit_rob_id == e_mon.id;
          2'd1: ok = {commit_valid, store_commit, flush} == 3'b010 &&
                     store_commit_rob_id == e_mon.id;
          default: ok = {commit_valid, store_commit, flush} == 3'b001 &&
                        flush_pc == e_mon.val;
        endcase
        if (!ok) begin
          bad++;
          $display("FAIL retire: got cv=%0b sc=%0b fl=%0b rd=%0d v=%0h id=%0d sid=%0d pc=%0h want kind=%0d rd=%0d v=%0h id=%0d",
                   commit_valid, store_commit, flush, commit_rd,
                   commit_value, commit_rob_id, store_commit_rob_id,
                   flush_pc, e_mon.kind, e_mon.rd, e_mon.val, e_mon.id);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] k, input logic [4:0] rd,
                      input logic [31:0] v, input logic [3:0] id);
    exp_t x;
    x.kind = k; x.rd = rd; x.val = v; x.id = id;
    exp_q.push_back(x);
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                       input logic pred, input logic [31:0] alt,
                       input logic dn, input logic [31:0] v);
    issue_valid = 1'b1; issue_type = t; issue_rd = rd;
    issue_pred_taken = pred; issue_alt_pc = alt;
    issue_done = dn; issue_value = v;
    cyc();
    issue_valid = 1'b0;
    m_tail = m_tail + 1'b1;
  endtask

  task automatic bcast(input logic rr, input logic [3:0] ri,
                       input logic [31:0] rv, input logic lr,
                       input logic [3:0] li, input logic [31:0] lv);
    rs_ready = rr; rs_rob_id = ri; rs_value = rv;
    lsb_ready = lr; lsb_rob_id = li; lsb_value = lv;
    cyc();
    rs_ready = 1'b0; lsb_ready = 1'b0;
  endtask

  task automatic drain(input string nm, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++)
      @(negedge clk);
    #1;
    chk(nm, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; issue_valid = 1'b0;
    rs_ready = 1'b0; lsb_ready = 1'b0;
    cyc(); cyc();
    chk("reset_state",
        {commit_valid, store_commit, flush, halt, rob_full,
         rob_tail, commit_value, flush_pc[15:0]}, 64'd0);
    rst = 1'b0;
    m_tail = '0;
    exp_q.delete();
  endtask

  initial begin
    tbl[0] = '{0, 0, 0,      0, 0, 0,      1, 0, 1, 32'h11, 0, 0};
    tbl[1] = '{1, 1, 32'h99, 0, 0, 0,      1, 2, 1, 32'h11, 0, 0};
    tbl[2] = '{1, 3, 32'hAB, 0, 0, 0,      3, 1, 1, 32'hAB, 1, 32'h11};
    tbl[3] = '{0, 0, 0,      1, 2, 32'h55, 2, 3, 1, 32'h55, 0, 0};
    tbl[4] = '{1, 2, 32'h66, 1, 3, 32'h77, 2, 3, 1, 32'h66, 1, 32'h77};
    tbl[5] = '{1, 0, 32'hEE, 1, 2, 32'h12, 0, 2, 1, 32'hEE, 1, 32'h12};
    tbl[6] = '{1, 5, 32'h1,  1, 6, 32'h2,  4, 7, 0, 0,      0, 0};

    // single done reg instruction
    do_reset();
    push(2'd0, 5'd5, 32'h11, m_tail);
    issue(T_REG, 5'd5, 0, 0, 1, 32'h11);
    chk("tail_after_issue", 64'(rob_tail), 64'd1);
    drain("drain_single", 10);
    cyc();
    chk("pulse_clears", 64'(commit_valid), 64'd0);

    // in-order commit behind a pending head, plus rdy freeze
    do_reset();
    push(2'd0, 5'd1, 32'h33, m_tail);
    issue(T_REG, 5'd1, 0, 0, 0, 32'h0);
    push(2'd0, 5'd2, 32'h22, m_tail);
    issue(T_REG, 5'd2, 0, 0, 1, 32'h22);
    rdy = 1'b0; issue_valid = 1'b1;
    cyc(); cyc(); cyc();
    chk("freeze_tail", 64'(rob_tail), 64'd2);
    rdy = 1'b1; issue_valid = 1'b0;
    cyc(); cyc();
    chk("no_early_commit", 64'(exp_q.size()), 64'd2);
    bcast(1, 0, 32'h33, 0, 0, 0);
    drain("drain_order", 10);

    // full buffer, refused issue, wrap, dual-bus writeback
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(2'd0, 5'(i + 1), 32'h100 + i, m_tail);
      issue(T_REG, 5'(i + 1), 0, 0, 0, 32'h0);
      if (i == 14) chk("not_full_15", 64'(rob_full), 64'd0);
    end
    chk("full_16", 64'(rob_full), 64'd1);
    chk("tail_wrap", 64'(rob_tail), 64'd0);
    issue_valid = 1'b1; issue_done = 1'b1;
    cyc();
    issue_valid = 1'b0;
    chk("refused_tail", 64'(rob_tail), 64'd0);
    bcast(1, 0, 32'h100, 0, 0, 0);
    chk("full_before_commit", 64'(rob_full), 64'd1);
    cyc();
    chk("full_drops", 64'(rob_full), 64'd0);
    m_tail = 4'd0;
    push(2'd0, 5'd9, 32'h200, m_tail);
    issue(T_REG, 5'd9, 0, 0, 0, 32'h0);
    chk("tail_after_wrap", 64'(rob_tail), 64'd1);
    for (int i = 1; i < 16; i += 2)
      bcast(1, 4'(i), 32'h100 + i, 1, 4'(i + 1),
            (i == 15) ? 32'h200 : 32'h100 + i + 1);
    drain("drain_full", 60);

    // mispredict flush, discarded issues, stale broadcasts
    do_reset();
    push(2'd2, 0, 32'h100, 0);
    issue(T_BR, 0, 0, 32'h100, 0, 0);
    issue(T_REG, 5'd3, 0, 0, 1, 32'h44);
    bcast(1, 0, 32'h1, 0, 0, 0);
    issue_valid = 1'b1; issue_type = T_REG; issue_done = 1'b1;
    issue_value = 32'h55;
    cyc();
    chk("flush_pulse", 64'(flush), 64'd1);
    chk("flush_pc", 64'(flush_pc), 64'h100);
    chk("flush_edge_no_issue", 64'(rob_tail), 64'd2);
    rs_ready = 1'b1; rs_rob_id = 4'd1; rs_value = 32'h77;
    cyc();
    issue_valid = 1'b0; rs_ready = 1'b0;
    chk("flush_clears", 64'({flush, rob_tail, rob_full}), 64'd0);
    m_tail = '0;
    bcast(1, 0, 32'hDEAD, 0, 0, 0);
    push(2'd0, 5'd6, 32'h66, m_tail);
    issue(T_REG, 5'd6, 0, 0, 0, 0);
    query_id1 = 4'd0;
    #1;
    chk("stale_not_ready", 64'(query_ready1), 64'd0);
    cyc(); cyc(); cyc();
    bcast(1, 0, 32'h66, 0, 0, 0);
    drain("drain_flush", 10);

    // correct prediction then store
    issue(T_BR, 0, 1, 32'h300, 1, 32'h1);
    push(2'd0, 5'd7, 32'h77, m_tail);
    issue(T_REG, 5'd7, 0, 0, 1, 32'h77);
    drain("drain_good_branch", 10);
    push(2'd1, 0, 0, m_tail);
    issue(T_ST, 0, 0, 0, 0, 0);
    bcast(0, 0, 0, 1, m_tail - 1'b1, 32'hFFFF);
    drain("drain_store", 10);

    // combinational query table under frozen state
    do_reset();
    push(2'd0, 5'd1, 32'h30, m_tail);
    issue(T_REG, 5'd1, 0, 0, 0, 0);
    push(2'd0, 5'd2, 32'h11, m_tail);
    issue(T_REG, 5'd2, 0, 0, 1, 32'h11);
    push(2'd0, 5'd3, 32'h32, m_tail);
    issue(T_REG, 5'd3, 0, 0, 0, 0);
    push(2'd0, 5'd4, 32'h33, m_tail);
    issue(T_REG, 5'd4, 0, 0, 0, 0);
    cyc();
    rdy = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rs_ready = tbl[i].rs_r; rs_rob_id = tbl[i].rs_id;
      rs_value = tbl[i].rs_v; lsb_ready = tbl[i].l_r;
      lsb_rob_id = tbl[i].l_id; lsb_value = tbl[i].l_v;
      query_id1 = tbl[i].q1; query_id2 = tbl[i].q2;
      #2;
      chk($sformatf("query1_v%0d", i),
          64'({query_ready1, query_value1}),
          64'({tbl[i].e_r1, tbl[i].e_v1}));
      chk($sformatf("query2_v%0d", i),
          64'({query_ready2, query_value2}),
          64'({tbl[i].e_r2, tbl[i].e_v2}));
    end
    rs_ready = 1'b0; lsb_ready = 1'b0;
    cyc();
    rdy = 1'b1;
    query_id1 = 4'd0;
    #1;
    chk("frozen_no_write", 64'(query_ready1), 64'd0);
    bcast(1, 0, 32'h30, 1, 2, 32'h32);
    bcast(1, 3, 32'h33, 0, 0, 0);
    drain("drain_query", 12);

    // exit retires, halt sticks and blocks later commits
    issue(T_EX, 0, 0, 0, 1, 0);
    issue(T_REG, 5'd8, 0, 0, 1, 32'h99);
    repeat (5) cyc();
    chk("halt_set", 64'(halt), 64'd1);
    repeat (5) cyc();
    chk("halt_sticky", 64'(halt), 64'd1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
